// File: rtl/countdown_timer_if.sv
// Load handshake plus control/status bundle for countdown_timer.
// master drives loads and control levels; slave is the timer itself.
interface countdown_timer_if #(
  parameter int SIZE = 16
);
  logic            load_valid;
  logic            load_ready;
  logic [SIZE-1:0] load_val;
  logic            en;
  logic            stop;
  logic            auto_reload;
  logic [SIZE-1:0] out;
  logic            busy;
  logic            expire;
  logic            below;

  modport master (
    output load_valid, load_val, en, stop, auto_reload,
    input  load_ready, out, busy, expire, below
  );

  modport slave (
    input  load_valid, load_val, en, stop, auto_reload,
    output load_ready, out, busy, expire, below
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, expire pulse and optional auto-reload; expire is registered (1 cycle).
// Loads take effect on the handshake edge; load_ready is low while running so requests stall without side effects.
module countdown_timer #(
  parameter int SIZE   = 16,
  parameter int THRESH = 10
) (
  input  logic                clk,
  input  logic                rst,
  countdown_timer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] THRESH_V = SIZE'(THRESH);
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);
  localparam logic [SIZE-1:0] ZERO     = '0;

  state_t          state_q, state_n;
  logic [SIZE-1:0] cnt_q, cnt_n;
  logic [SIZE-1:0] reload_q, reload_n;
  logic            expire_q, expire_n;
  logic            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      reload_q <= reload_n;
      expire_q <= expire_n;
    end
  end

  assign accept = bus.load_valid && (state_q != RUN);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    reload_n = reload_q;
    expire_n = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        // A load wins over resuming from PAUSE; a zero load expires on the spot.
        if (accept) begin
          cnt_n    = bus.load_val;
          reload_n = bus.load_val;
          if (bus.load_val == ZERO) begin
            state_n  = IDLE;
            expire_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end else if (state_q == PAUSE && !bus.stop) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = PAUSE;
        end else if (bus.en) begin
          if (cnt_q > ONE) begin
            cnt_n = cnt_q - ONE;
          end else begin
            expire_n = 1'b1;
            if (bus.auto_reload) begin
              cnt_n = reload_q;
            end else begin
              cnt_n   = ZERO;
              state_n = IDLE;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = ZERO;
      end
    endcase
  end

  assign bus.load_ready = (state_q != RUN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out        = cnt_q;
  assign bus.expire     = expire_q;
  assign bus.below      = (cnt_q <= THRESH_V);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the timer.
module tb_countdown_timer;
  localparam int SIZE   = 16;
  localparam int THRESH = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  countdown_timer_if #(.SIZE(SIZE)) bus ();

  countdown_timer #(.SIZE(SIZE), .THRESH(THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the timer as a mode plus an integer count.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  int m_mode;
  int m_cnt;
  int m_reload;
  int m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode   <= M_IDLE;
      m_cnt    <= 0;
      m_reload <= 0;
      m_exp    <= 0;
    end else begin
      m_exp <= 0;
      if (m_mode != M_RUN && bus.load_valid) begin
        m_cnt    <= int'(bus.load_val);
        m_reload <= int'(bus.load_val);
        m_mode   <= (bus.load_val == 0) ? M_IDLE : M_RUN;
        m_exp    <= (bus.load_val == 0) ? 1 : 0;
      end else if (m_mode == M_PAUSE) begin
        if (!bus.stop) m_mode <= M_RUN;
      end else if (m_mode == M_RUN && !bus.stop && bus.en) begin
        if (m_cnt - 1 > 0) begin
          m_cnt <= m_cnt - 1;
        end else begin
          m_exp <= 1;
          if (bus.auto_reload) begin
            m_cnt <= m_reload;
          end else begin
            m_cnt  <= 0;
            m_mode <= M_IDLE;
          end
        end
      end else if (m_mode == M_RUN && bus.stop) begin
        m_mode <= M_PAUSE;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_out",    bus.out,        m_cnt);
      chk("model_busy",   bus.busy,       (m_mode != M_IDLE));
      chk("model_expire", bus.expire,     m_exp);
      chk("model_ready",  bus.load_ready, (m_mode != M_RUN));
      chk("model_below",  bus.below,      (m_cnt <= THRESH));
      chk("run_nonzero",  (!bus.load_ready && bus.out == 0), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_val    = '0;
    bus.en          = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    #2;
    chk("rst_out",    bus.out, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_expire", bus.expire, 0);
    chk("rst_ready",  bus.load_ready, 1);
    chk("rst_below",  bus.below, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Load 5, count down to expiry.
    bus.load_valid = 1'b1; bus.load_val = 16'd5; bus.en = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("t1_out_load", bus.out, 5);
    chk("t1_model_load", m_cnt, 5);
    for (int v = 4; v >= 0; v--) begin
      tick();
      chk("t1_out", bus.out, v);
      chk("t1_expire", bus.expire, (v == 0));
      chk("t1_busy", bus.busy, (v != 0));
      chk("t1_below", bus.below, 1);
    end
    tick();
    chk("t1_expire_clear", bus.expire, 0);

    // Load 12 with auto-reload.
    bus.load_valid = 1'b1; bus.load_val = 16'd12; bus.auto_reload = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("t2_out_load", bus.out, 12);
    chk("t2_below_load", bus.below, 0);
    for (int v = 11; v >= 1; v--) begin
      tick();
      chk("t2_out", bus.out, v);
      chk("t2_below", bus.below, (v <= 10));
      chk("t2_expire", bus.expire, 0);
    end
    tick();
    chk("t2_reload_out", bus.out, 12);
    chk("t2_reload_expire", bus.expire, 1);
    chk("t2_reload_busy", bus.busy, 1);
    bus.auto_reload = 1'b0;
    repeat (12) tick();
    chk("t2_drain_out", bus.out, 0);
    chk("t2_drain_busy", bus.busy, 0);

    // Load 8, pause at 6 for three edges, resume.
    bus.load_valid = 1'b1; bus.load_val = 16'd8;
    tick();
    bus.load_valid = 1'b0;
    tick();
    tick();
    chk("t3_out_6", bus.out, 6);
    bus.stop = 1'b1;
    repeat (3) begin
      tick();
      chk("t3_pause_out", bus.out, 6);
      chk("t3_pause_ready", bus.load_ready, 1);
      chk("t3_pause_busy", bus.busy, 1);
    end
    bus.stop = 1'b0;
    tick();
    chk("t3_resume_out", bus.out, 6);
    chk("t3_resume_ready", bus.load_ready, 0);
    tick();
    chk("t3_resume_dec", bus.out, 5);

    // Load request held during RUN stalls until expiry.
    bus.load_valid = 1'b1; bus.load_val = 16'd3;
    for (int v = 4; v >= 1; v--) begin
      tick();
      chk("t4_stall_out", bus.out, v);
      chk("t4_stall_ready", bus.load_ready, 0);
    end
    tick();
    chk("t4_expire_out", bus.out, 0);
    chk("t4_expire", bus.expire, 1);
    chk("t4_ready", bus.load_ready, 1);
    tick();
    bus.load_valid = 1'b0;
    chk("t4_load_out", bus.out, 3);
    chk("t4_load_busy", bus.busy, 1);
    repeat (3) tick();
    chk("t4_drain_out", bus.out, 0);

    // Zero load in IDLE.
    tick();
    bus.load_valid = 1'b1; bus.load_val = 16'd0;
    tick();
    bus.load_valid = 1'b0;
    chk("t5_zero_out", bus.out, 0);
    chk("t5_zero_busy", bus.busy, 0);
    chk("t5_zero_expire", bus.expire, 1);
    tick();
    chk("t5_zero_expire_clear", bus.expire, 0);

    // Load 1 with auto-reload: expire every cycle.
    bus.load_valid = 1'b1; bus.load_val = 16'd1; bus.auto_reload = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("t6_load_out", bus.out, 1);
    chk("t6_load_expire", bus.expire, 0);
    repeat (3) begin
      tick();
      chk("t6_out", bus.out, 1);
      chk("t6_expire", bus.expire, 1);
    end
    bus.auto_reload = 1'b0;
    tick();
    chk("t6_end_out", bus.out, 0);
    chk("t6_end_busy", bus.busy, 0);
    chk("t6_end_expire", bus.expire, 1);

    // Asynchronous reset mid-count at 7.
    bus.load_valid = 1'b1; bus.load_val = 16'd10;
    tick();
    bus.load_valid = 1'b0;
    repeat (3) tick();
    chk("t7_pre_out", bus.out, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_out", bus.out, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_expire", bus.expire, 0);
    chk("t7_rst_ready", bus.load_ready, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.auto_reload = 1'b1;
    repeat (4) begin
      tick();
      chk("t7_idle_out", bus.out, 0);
      chk("t7_idle_busy", bus.busy, 0);
      chk("t7_idle_expire", bus.expire, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.load_valid  = ($urandom_range(0, 99) < 12);
      bus.load_val    = ($urandom_range(0, 9) == 0) ? SIZE'($urandom_range(0, 40))
                                                    : SIZE'($urandom_range(0, 6));
      bus.en          = ($urandom_range(0, 3) != 0);
      bus.stop        = ($urandom_range(0, 99) < 10);
      bus.auto_reload = ($urandom_range(0, 1) == 1);
      tick();
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
